// File: rtl/marine_radar_pulse_packer_if.sv
// rtl/marine_radar_pulse_packer_if.sv - sample input and packed word output of the radar pulse packer
interface marine_radar_pulse_packer_if #(
    parameter int SAMPLE_WIDTH = 12
);
    logic                    sample_strobe;
    logic [SAMPLE_WIDTH-1:0] sample;
    logic                    out_strobe;
    logic [15:0]             out_data;

    modport master (
        input  sample_strobe,
        input  sample,
        output out_strobe,
        output out_data
    );

    modport slave (
        output sample_strobe,
        output sample,
        input  out_strobe,
        input  out_data
    );
endinterface

// File: rtl/marine_radar_pulse_packer.sv
// rtl/marine_radar_pulse_packer.sv - frames each radar trigger into header, video samples and zero pad words
// Optional MARINE_RADAR_PACK8_EN: pack the top 8 bits of two samples per output word.
module marine_radar_pulse_packer #(
    parameter int          SAMPLE_WIDTH = 12,
    parameter int          PKT_WORDS    = 256,
    parameter logic [15:0] MAGIC        = 16'hFEED
) (
    input  logic                           rxclk,
    input  logic                           reset_n,
    input  logic                           enable,
    input  logic                           trigger,
    input  logic [15:0]                    n_samples,
    input  logic [15:0]                    delay,
    output logic                           busy,
    output logic [31:0]                    trig_count,
    output logic [15:0]                    missed_trig,
    marine_radar_pulse_packer_if.master    bus
);
    localparam int WCW = (PKT_WORDS > 1) ? $clog2(PKT_WORDS) : 1;

    typedef enum logic [2:0] {IDLE, HEADER, DELAY, CAPTURE, PAD} state_t;

    state_t          state;
    logic            trig_s1, trig_s2, trig_s3;
    logic            trig_rise;
    logic [15:0]     n_l, d_l;
    logic [15:0]     scnt;
    logic [1:0]      hidx;
    logic [WCW-1:0]  wcnt;
    logic [WCW-1:0]  wcnt_inc;
    logic            last_sample;

`ifdef MARINE_RADAR_PACK8_EN
    logic            phase;
    logic [7:0]      hold;
    logic [7:0]      top8;
    assign top8 = bus.sample[SAMPLE_WIDTH-1 -: 8];
`else
    logic [15:0]     sample_ext;
    always_comb begin
        sample_ext = '0;
        sample_ext[SAMPLE_WIDTH-1:0] = bus.sample;
    end
`endif

    assign trig_rise   = trig_s2 & ~trig_s3;
    assign wcnt_inc    = wcnt + WCW'(1);
    assign last_sample = (scnt == n_l - 16'd1);
    assign busy        = (state != IDLE);

    // s3 is the edge-detect history; only s1/s2 form the synchronizer
    always_ff @(posedge rxclk or negedge reset_n) begin
        if (!reset_n) begin
            trig_s1 <= 1'b0;
            trig_s2 <= 1'b0;
            trig_s3 <= 1'b0;
        end else begin
            trig_s1 <= trigger;
            trig_s2 <= trig_s1;
            trig_s3 <= trig_s2;
        end
    end

    always_ff @(posedge rxclk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            bus.out_strobe <= 1'b0;
            bus.out_data   <= 16'h0000;
            trig_count     <= 32'd0;
            missed_trig    <= 16'd0;
            n_l            <= 16'd0;
            d_l            <= 16'd0;
            scnt           <= 16'd0;
            hidx           <= 2'd0;
            wcnt           <= '0;
`ifdef MARINE_RADAR_PACK8_EN
            phase          <= 1'b0;
            hold           <= 8'h00;
`endif
        end else begin
            bus.out_strobe <= 1'b0;

            if (trig_rise) begin
                if (state == IDLE && enable) begin
                    trig_count <= trig_count + 32'd1;
                    n_l        <= n_samples;
                    d_l        <= delay;
                    wcnt       <= '0;
                    hidx       <= 2'd0;
                    state      <= HEADER;
                end else if (missed_trig != 16'hFFFF) begin
                    missed_trig <= missed_trig + 16'd1;
                end
            end

            case (state)
                HEADER: begin
                    bus.out_strobe <= 1'b1;
                    wcnt           <= wcnt_inc;
                    hidx           <= hidx + 2'd1;
                    case (hidx)
                        2'd0:    bus.out_data <= MAGIC;
                        2'd1:    bus.out_data <= trig_count[15:0];
                        2'd2:    bus.out_data <= trig_count[31:16];
                        default: bus.out_data <= n_l;
                    endcase
                    if (hidx == 2'd3) begin
                        scnt <= 16'd0;
`ifdef MARINE_RADAR_PACK8_EN
                        phase <= 1'b0;
`endif
                        if (d_l != 16'd0)
                            state <= DELAY;
                        else if (n_l != 16'd0)
                            state <= CAPTURE;
                        else
                            state <= PAD;
                    end
                end

                DELAY: begin
                    if (bus.sample_strobe) begin
                        if (scnt == d_l - 16'd1) begin
                            scnt  <= 16'd0;
                            state <= (n_l != 16'd0) ? CAPTURE : PAD;
                        end else begin
                            scnt <= scnt + 16'd1;
                        end
                    end
                end

                CAPTURE: begin
                    if (bus.sample_strobe) begin
                        scnt <= scnt + 16'd1;
`ifdef MARINE_RADAR_PACK8_EN
                        // Odd counts flush the lone first half on the final strobe
                        if (!phase) begin
                            hold <= top8;
                            if (last_sample) begin
                                bus.out_strobe <= 1'b1;
                                bus.out_data   <= {8'h00, top8};
                                wcnt           <= wcnt_inc;
                            end else begin
                                phase <= 1'b1;
                            end
                        end else begin
                            bus.out_strobe <= 1'b1;
                            bus.out_data   <= {top8, hold};
                            wcnt           <= wcnt_inc;
                            phase          <= 1'b0;
                        end
`else
                        bus.out_strobe <= 1'b1;
                        bus.out_data   <= sample_ext;
                        wcnt           <= wcnt_inc;
`endif
                        if (last_sample)
                            state <= PAD;
                    end
                end

                PAD: begin
                    if (wcnt == '0) begin
                        state <= IDLE;
                    end else begin
                        bus.out_strobe <= 1'b1;
                        bus.out_data   <= 16'h0000;
                        wcnt           <= wcnt_inc;
                        if (wcnt_inc == '0)
                            state <= IDLE;
                    end
                end

                default: ;
            endcase
        end
    end
endmodule

// File: doc/marine_radar_pulse_packer.md
Name: marine_radar_pulse_packer

Overview:
- Sits directly upstream of the USB-side radar receive FIFO, in the rxclk domain.
- On each radar trigger pulse it emits one framed 16-bit word stream: a 4-word header, the pulse's digitized video samples, then zero padding to a 256-word (512-byte) packet boundary.
- Output strobe/data connect to the FIFO write side, one word per strobe.

Parameters:
SAMPLE_WIDTH, 12, ADC video sample width (bits, <=16).
PKT_WORDS, 256, packet length in 16-bit words; must be a power of two.
MAGIC, 16'hFEED, first header word.

Ports:
rxclk  input  1  DSP clock; all logic on posedge.
reset_n  input  1  asynchronous, active-low reset.
enable  input  1  level; 0 = ignore triggers; an in-flight packet still completes.
trigger  input  1  raw radar trigger, asynchronous; 2-flop synchronized internally.
sample_strobe  input  1  one-cycle qualifier for sample.
sample  input  SAMPLE_WIDTH  video sample, valid when sample_strobe=1.
n_samples  input  16  samples per pulse; latched at accepted trigger.
delay  input  16  sample_strobes skipped after trigger before capture; latched at trigger.
out_strobe  output  1  one-cycle word-valid to buffer.
out_data  output  16  word, valid with out_strobe.
busy  output  1  1 whenever state != IDLE.
trig_count  output  32  accepted triggers since reset.
missed_trig  output  16  triggers seen while busy or disabled; saturates at 16'hFFFF.

Behaviour:
- Reset (reset_n=0, asynchronous): state IDLE; out_strobe=0, out_data=0, busy=0, trig_count=0, missed_trig=0; synchronizer and edge-detect flops 0.
- Trigger detection: rising edge of synchronized trigger. Accepted only if state=IDLE and enable=1; otherwise missed_trig increments (saturating).
- On accept: trig_count increments; n_samples and delay latched; word counter (log2 PKT_WORDS bits) cleared; go to HEADER.
- Latency: first header word has out_strobe=1 exactly 3 rxclk cycles after the first posedge at which trigger is sampled high.
- HEADER: emits 4 words on 4 consecutive cycles, ignoring sample_strobe: MAGIC; trig_count[15:0]; trig_count[31:16]; latched n_samples. trig_count fields carry the already-incremented value (first packet = 1). Then: DELAY if delay!=0, else CAPTURE if n_samples!=0, else PAD.
- DELAY: counts sample_strobes; after delay strobes, go to CAPTURE, or to PAD if n_samples=0. The strobe completing the delay is not captured.
- CAPTURE: on each sample_strobe, emit {zero-extend, sample} (right-justified). After n_samples words, go to PAD. Samples emitted with a one-cycle registered delay from sample_strobe.
- PAD: emit 16'h0000 every cycle until the word counter wraps to 0, then IDLE. If it is already 0 on entry (total words multiple of PKT_WORDS), go to IDLE with no pad words.
- Word counter increments on every out_strobe and wraps modulo PKT_WORDS, so packets may span several PKT_WORDS blocks.
- Multi-cycle output runs are at most one word/cycle; no backpressure. Downstream overrun is the buffer's concern.
- enable falling mid-packet: no effect on the current packet.
- Reset mid-packet: immediate abort; no further words emitted.

Optional Feature:
MARINE_RADAR_PACK8_EN
- Defined: CAPTURE packs the top 8 bits of two consecutive samples per word: first sample in [7:0], second in [15:8]. Odd n_samples: the last word has [15:8]=0 and is emitted on the final sample's strobe. Header word 3 still carries n_samples (sample count, not word count).
- Undefined: one sample per word as above.

Test Plan:
- Trigger with n_samples=4, delay=0, samples 1,2,3,4 -> words FEED,0001,0000,0004,0001,0002,0003,0004, then 248 zeros, total 256; busy drops after the last word.
- delay=3, n_samples=2, sample strobes carrying 10..14 -> captured words 000D,000E; 3-cycle trigger-to-first-word latency checked.
- n_samples=252 -> 256 words total, zero pad words; n_samples=253 -> 512 words total with 255 pads.
- Second trigger mid-packet, and a trigger with enable=0 -> missed_trig=2; trig_count unchanged; current packet intact.
- reset_n asserted mid-CAPTURE -> out_strobe=0 immediately; next trigger header shows trig_count=1.
- PACK8_EN, n_samples=3, samples 12'h123,12'h456,12'h789 -> words 4512, 0078 after the header.
